// File: rtl/mdu_param.sv
// Purpose: parametrised multiply/divide unit with MAC ops and one-level HI/LO rollback.
// Latency: mthi/mtlo visible next cycle; mult-class ops MULT_CYCLES, div ops DIV_CYCLES busy cycles.
// Backpressure: busy high while an op is in flight; starts seen during busy are ignored.
//
// Ports:
//   clk, reset (async, active-low)
//   start/op/a/b : op issue (op 1..10 valid, others no-op)
//   rollback     : abort in-flight op and restore HI/LO from the last-accept snapshot
//   busy/done    : registered status; done pulses the cycle a multi-cycle result appears
//   hi/lo        : committed HI/LO registers
module mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rollback,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MTHI  = 4'd3;
    localparam logic [3:0] OP_MTLO  = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_DIVU  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);

    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] snap_q, snap_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               busy_q, busy_d, done_q, done_d;

    // Datapath works on the latched operands so it only matters at the commit cycle.
    logic               op_signed, neg_a, neg_b, div_by_zero, accept, commit;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, hl_cur, res;
    logic [WIDTH-1:0]   mag_a, mag_b, dvsr, uq, ur, quo, rem;

    always_comb begin
        op_signed = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                    (op_q == OP_MADD) || (op_q == OP_MSUB);
        ext_a     = {{WIDTH{op_signed & a_q[WIDTH-1]}}, a_q};
        ext_b     = {{WIDTH{op_signed & b_q[WIDTH-1]}}, b_q};
        // Low 2*WIDTH bits of the extended product are correct for both signednesses.
        prod      = ext_a * ext_b;
        hl_cur    = {hi_q, lo_q};

        // Sign-magnitude division: truncation toward zero, remainder follows dividend.
        // The most-negative / -1 case falls out naturally: magnitude 2^(W-1) negates to itself.
        neg_a       = op_signed & a_q[WIDTH-1];
        neg_b       = op_signed & b_q[WIDTH-1];
        mag_a       = neg_a ? -a_q : a_q;
        mag_b       = neg_b ? -b_q : b_q;
        div_by_zero = (b_q == '0);
        dvsr        = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        uq          = mag_a / dvsr;
        ur          = mag_a % dvsr;
        quo         = (neg_a ^ neg_b) ? -uq : uq;
        rem         = neg_a ? -ur : ur;

        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_MADD, OP_MADDU: res = hl_cur + prod;
            OP_MSUB, OP_MSUBU: res = hl_cur - prod;
            OP_DIV, OP_DIVU:   res = div_by_zero ? hl_cur : {rem, quo};
            default:           res = hl_cur;
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        snap_d = snap_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        accept = start & ~busy_q & ~rollback & (op >= OP_MULT) & (op <= OP_MSUBU);
        commit = busy_q & (cnt_q == CNT_ONE) & ~rollback;

        if (rollback) begin
            {hi_d, lo_d} = snap_q;
            busy_d       = 1'b0;
            cnt_d        = '0;
        end else if (commit) begin
            {hi_d, lo_d} = res;
            busy_d       = 1'b0;
            cnt_d        = '0;
            done_d       = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (accept) begin
            snap_d = {hi_q, lo_q};
            case (op)
                OP_MTHI: hi_d = a;
                OP_MTLO: lo_d = a;
                default: begin
                    op_d   = op;
                    a_d    = a;
                    b_d    = b;
                    busy_d = 1'b1;
                    cnt_d  = ((op == OP_DIV) || (op == OP_DIVU)) ? CNT_DIV : CNT_MULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            snap_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu_param.md
# mdu_param

Parametrised multi-cycle multiply/divide unit for the Execute stage of the pipelined MIPS core. It replaces the fixed-width MDU. Width and latencies are configurable, it adds multiply-accumulate ops, and it has a precise rollback: an exception on the instruction one stage downstream undoes that instruction's HI/LO effect. The hazard unit stalls on `busy`; CP0 drives `rollback`.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width (≥ 2)
- `MULT_CYCLES`, 5, busy cycles for mult/multu/madd*/msub* (≥ 1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥ 1)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: accept `op` this cycle (qualified, see Operation)
- `op` in 4: 1 mult, 2 multu, 3 mthi, 4 mtlo, 5 div, 6 divu, 7 madd, 8 maddu, 9 msub, 10 msubu; 0 and 11-15 are no-ops
- `a` in WIDTH: rs operand, already forwarded
- `b` in WIDTH: rt operand, already forwarded
- `rollback` in 1: cancel the most recently accepted op and restore HI/LO
- `busy` out 1: multi-cycle op in flight
- `done` out 1: one-cycle pulse in the cycle HI/LO first shows a multi-cycle result
- `hi` out WIDTH: committed HI
- `lo` out WIDTH: committed LO

## Operation
- Reset (`reset`=0): `hi`, `lo`, snapshot, counter, `busy` and `done` all go to 0 immediately, whatever operation is in flight.
- Accept condition: `start` & ~`busy` & ~`rollback` & `op` in 1..10. When `start` arrives while `busy`=1 it is ignored; the hazard unit must not issue it.
- On accept:
  - The snapshot register takes the current {hi, lo}.
  - mthi/mtlo: write `a` to hi or lo at this edge. No busy.
  - Multi-cycle ops: latch the operands and op, load the counter with MULT_CYCLES or DIV_CYCLES, and set busy.
- Arithmetic (2·WIDTH-bit product P; {hi, lo} read as one 2·WIDTH value H):
  - mult/multu: H = P (signed or unsigned).
  - madd/maddu: H = H + P.
  - msub/msubu: H = H − P. H wraps modulo 2^(2·WIDTH).
  - madd/msub use the {hi, lo} value present when the result commits.
- Division: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Signed −2^(WIDTH−1) / −1 gives lo = −2^(WIDTH−1), hi = 0.
  - Divide by zero (b = 0): hi and lo stay unchanged; busy and done still run their normal timing.
- Commit: when the counter reaches its last busy cycle, {hi, lo} update at that edge, busy clears, and done pulses for one cycle.
- Rollback (`rollback`=1 at an edge):
  - Any in-flight op is aborted: counter cleared, busy=0, no commit, no done.
  - {hi, lo} are restored from the snapshot.
  - A simultaneous `start` is dropped.
  - Rollback with nothing accepted since the last snapshot restores the snapshot anyway; the snapshot equals the current value unless a commit happened after it.
- The snapshot is only overwritten on accept. A second rollback before any new accept is therefore idempotent.

## Timing
- Accept at edge t: busy=1 for cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES).
- The result commits at the edge ending cycle t+N. In cycle t+N+1, hi/lo show the new value, busy=0 and done=1.
- mthi/mtlo: the new value is visible in cycle t+1; busy stays 0 and done stays 0.
- A new op can be accepted in cycle t+N+1. Back-to-back accepts are therefore N+1 cycles apart.
- `rollback` takes effect at the next edge; restored values are visible in the following cycle.
- The outputs `busy`, `done`, `hi` and `lo` are registered. There are no combinational paths from any input to any output.

## Test plan
- mult a=0xFFFFFFFF, b=2: busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE and done=1. multu with the same operands gives hi=1, lo=0xFFFFFFFE.
- div a=−7, b=2: busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 gives lo=3, hi=1. div 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- mtlo 10, mthi 0, then madd 3×4: lo=22, hi=0. Then msubu 5×5: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Rollback:
  - With hi=1, lo=2: multu 3×3 accepted at t, rollback at t+1. busy=0 at t+2, hi=1, lo=2, done never pulses.
  - mthi 7 followed by rollback: hi returns to 1.
- With hi=5, lo=6: div by 0 gives busy for 10 cycles and done, with hi=5, lo=6 afterwards. `start` held during busy is ignored, checked via the HI/LO result.
- Assert `reset`=0 mid-division at cycle 4: busy, done, hi and lo go to 0 asynchronously. After release, busy stays 0 until the next accepted start.
